fetch_align: RTL

Fetch-side instruction aligner feeding the gshare branch predictor and decode. It requests word-aligned 32-bit words from the instruction memory/cache and keeps them in a 4-halfword buffer. From that buffer it extracts one complete RV32IMC instruction per cycle (16- or 32-bit, any halfword alignment) and presents it with its PC and the sequential successors used for return-address and fall-through prediction.

---
 rtl/fetch_align.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_align.sv
// Fetch-side aligner: fetches word-aligned 32-bit words into a 4-halfword buffer
// and presents one complete RV32IMC instruction (16- or 32-bit) per cycle.
module fetch_align #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_valid_i,
   input  logic [31:0] mem_data_i,
   output logic        fetch_valid_o,
   output logic [31:0] inst_o,
   output logic        is_comp_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc2_o,
   output logic [31:0] pc4_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [2:0]  count_q, count_d;
   logic        drop_low_q, drop_low_d;
   logic [15:0] hw_q [4];
   logic [15:0] hw_d [4];
   logic [15:0] shf_s [4];

   logic        head_comp_s, head_ok_s, room_s, consume_s, accept_s;
   logic [2:0]  n_cons_s, keep_s;

   assign head_comp_s   = (hw_q[0][1:0] != 2'b11);
   assign head_ok_s     = ((count_q >= 3'd1) && head_comp_s) || (count_q >= 3'd2);
   assign fetch_valid_o = head_ok_s && !flush_i;
   assign room_s        = (count_q <= 3'd2);
   assign consume_s     = fetch_valid_o && !stall_i;
   assign n_cons_s      = !consume_s ? 3'd0 : (head_comp_s ? 3'd1 : 3'd2);
   assign keep_s        = count_q - n_cons_s;

   // The request is held through WAIT/DROP so the memory side sees a stable handshake.
   assign mem_req_o  = rst_ni && (((state_q == S_IDLE) && room_s && !flush_i) ||
                                  (state_q == S_WAIT) || (state_q == S_DROP));
   assign mem_addr_o = (state_q == S_IDLE) ? fetch_addr_q : req_addr_q;
   assign accept_s   = !flush_i && mem_valid_i &&
                       (((state_q == S_IDLE) && room_s) || (state_q == S_WAIT));

   assign is_comp_o = (count_q != 3'd0) && head_comp_s;
   assign inst_o    = head_comp_s ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
   assign pc_o      = pc_q;
   assign pc2_o     = pc_q + 32'd2;
   assign pc4_o     = pc_q + 32'd4;

   // Next-state: consume/shift, append accepted word, FSM, then flush override.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      req_addr_d   = req_addr_q;
      drop_low_d   = drop_low_q;
      count_d      = keep_s;
      shf_s        = hw_q;

      case (n_cons_s)
         3'd1: begin
            shf_s[0] = hw_q[1];
            shf_s[1] = hw_q[2];
            shf_s[2] = hw_q[3];
         end
         3'd2: begin
            shf_s[0] = hw_q[2];
            shf_s[1] = hw_q[3];
         end
         default: begin
            shf_s = hw_q;
         end
      endcase
      hw_d = shf_s;

      if (consume_s) begin
         pc_d = pc_q + (head_comp_s ? 32'd2 : 32'd4);
      end else begin
         pc_d = pc_q;
      end

      if (accept_s) begin
         for (int i = 0; i < 4; i++) begin
            if (drop_low_q) begin
               if (3'(i) == keep_s) begin
                  hw_d[i] = mem_data_i[31:16];
               end else begin
                  hw_d[i] = shf_s[i];
               end
            end else begin
               if (3'(i) == keep_s) begin
                  hw_d[i] = mem_data_i[15:0];
               end else if (3'(i) == (keep_s + 3'd1)) begin
                  hw_d[i] = mem_data_i[31:16];
               end else begin
                  hw_d[i] = shf_s[i];
               end
            end
         end
         count_d      = keep_s + (drop_low_q ? 3'd1 : 3'd2);
         drop_low_d   = 1'b0;
         fetch_addr_d = fetch_addr_q + 32'd4;
      end else begin
         count_d = keep_s;
      end

      case (state_q)
         S_IDLE: begin
            req_addr_d = fetch_addr_q;
            if (room_s && !mem_valid_i) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT:  state_d = mem_valid_i ? S_IDLE : S_WAIT;
         S_DROP:  state_d = mem_valid_i ? S_IDLE : S_DROP;
         default: state_d = S_IDLE;
      endcase

      // An outstanding request must still be retired, so WAIT/DROP fall into DROP.
      if (flush_i) begin
         count_d      = 3'd0;
         pc_d         = redirect_pc_i & ~32'h0000_0001;
         fetch_addr_d = redirect_pc_i & ~32'h0000_0003;
         drop_low_d   = redirect_pc_i[1];
         if (((state_q == S_WAIT) || (state_q == S_DROP)) && !mem_valid_i) begin
            state_d = S_DROP;
         end else begin
            state_d = S_IDLE;
         end
      end else begin
         drop_low_d = drop_low_d;
      end
   end

   // State and buffer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC & ~32'h0000_0003;
         req_addr_q   <= RESET_PC & ~32'h0000_0003;
         count_q      <= 3'd0;
         drop_low_q   <= RESET_PC[1];
         for (int i = 0; i < 4; i++) begin
            hw_q[i] <= 16'h0000;
         end
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         count_q      <= count_d;
         drop_low_q   <= drop_low_d;
         for (int i = 0; i < 4; i++) begin
            hw_q[i] <= hw_d[i];
         end
      end
   end

endmodule
